// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path widths, types and constants
package cpu_pkg;
  localparam int ADDR_W = 6;
  localparam int INST_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;
  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } fetch_pkt_t;
  localparam inst_t NOP_INST = 32'h0007_8000;
endpackage

// File: rtl/ifetch_skid_buf.sv
// ifetch_skid_buf: one-entry skid buffer and output mux between the memory return and decode
module ifetch_skid_buf
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  fetch_pkt_t in_pkt,
  input  logic       ready,
  input  logic       flush,
  output logic       out_valid,
  output fetch_pkt_t out_pkt,
  output logic       buf_v
);
  logic       buf_v_q, buf_v_d;
  fetch_pkt_t buf_q, buf_d;
  // a full buffer blocks issue upstream, so it never sees a second word while full
  always_comb begin
    buf_v_d   = flush ? 1'b0 : buf_v_q ? !ready : in_valid & !ready;
    buf_d     = (in_valid & !buf_v_q & !ready & !flush) ? in_pkt : buf_q;
    out_valid = (buf_v_q | in_valid) & !flush;
    out_pkt   = !out_valid ? '0 : buf_v_q ? buf_q : in_pkt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_v_q <= 1'b0;
      buf_q   <= '{inst: NOP_INST, pc: '0};
    end else begin
      buf_v_q <= buf_v_d;
      buf_q   <= buf_d;
    end
  end
  assign buf_v = buf_v_q;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, issue and squash control for a 1-cycle instruction memory
// Optional IFETCH_PERF_EN adds fetch_cnt/squash_cnt performance counters.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC = '0
) (
  input  logic  clk,
  input  logic  reset,
  output addr_t imem_addr,
  input  inst_t imem_data,
  input  logic  stall,
  input  logic  redirect_valid,
  input  addr_t redirect_pc,
  output logic  inst_valid,
  input  logic  inst_ready,
  output inst_t inst_out,
  output addr_t inst_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] squash_cnt
`endif
);
  addr_t      pc_q, pc_d, infl_pc_q, infl_pc_d;
  logic       infl_q, infl_d, issue, buf_v;
  fetch_pkt_t ret_pkt, out_pkt;
  // a redirect restarts fetch regardless of what is held, since held words are squashed
  always_comb begin
    imem_addr = redirect_valid ? redirect_pc : pc_q;
    issue     = !stall & (redirect_valid | (!buf_v & (!infl_q | inst_ready)));
    pc_d      = issue ? imem_addr + addr_t'(1) : imem_addr;
    infl_d    = issue;
    infl_pc_d = issue ? imem_addr : infl_pc_q;
    ret_pkt   = '{inst: imem_data, pc: infl_pc_q};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end
  ifetch_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (infl_q),
    .in_pkt   (ret_pkt),
    .ready    (inst_ready),
    .flush    (redirect_valid),
    .out_valid(inst_valid),
    .out_pkt  (out_pkt),
    .buf_v    (buf_v)
  );
  assign inst_out = out_pkt.inst;
  assign inst_pc  = out_pkt.pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, squash_cnt_q, squash_cnt_d;
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(inst_valid & inst_ready);
    squash_cnt_d = squash_cnt_q + 32'(redirect_valid & (infl_q | buf_v));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end
  assign fetch_cnt  = fetch_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and random checks of instruction_fetch against a fetch-stream model
module tb_instruction_fetch;
  import cpu_pkg::*;
  logic  clk = 1'b0, reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b1;
  logic  inst_valid;
  addr_t imem_addr, inst_pc, redirect_pc = '0;
  inst_t imem_data, inst_out;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_cnt, squash_cnt;
`endif
  int checks = 0, errors = 0;
  int exp_pc, hs, fexp;
  bit hold, last_stall;
  addr_t hold_pc, last_addr;

  always #5 clk = ~clk;
  always @(posedge clk) imem_data <= 32'h1000_0000 + 32'(imem_addr);

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .squash_cnt    (squash_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = 0; hold = 0; last_stall = 0; fexp = 0;
  endtask

  // stream model: every delivered word is mem[pc], pcs are consecutive except at a redirect
  task automatic sample();
    @(negedge clk);
    if (!inst_valid) begin
      check("idle_inst", inst_out, 0);
      check("idle_pc", inst_pc, 0);
    end
    if (redirect_valid) begin
      check("redir_valid", inst_valid, 0);
      check("redir_addr", imem_addr, redirect_pc);
    end
    if (inst_valid) begin
      check("word", inst_out, 32'h1000_0000 + 32'(inst_pc));
      check("order", inst_pc, exp_pc);
    end
    if (hold && !redirect_valid) begin
      check("hold_valid", inst_valid, 1);
      check("hold_pc", inst_pc, hold_pc);
    end
    if (last_stall && !redirect_valid) check("stall_addr", imem_addr, last_addr);
`ifdef IFETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, fexp);
`endif
    if (redirect_valid) exp_pc = int'(redirect_pc);
    else if (inst_valid && inst_ready) exp_pc = (int'(inst_pc) + 1) % 64;
    if (inst_valid && inst_ready) begin fexp++; hs++; end
    hold = inst_valid && !inst_ready && !redirect_valid;
    hold_pc = inst_pc;
    last_stall = stall;
    last_addr = imem_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    sample();
    check("rst_valid", inst_valid, 0);
    check("rst_addr", imem_addr, 0);
`ifdef IFETCH_PERF_EN
    check("rst_cnts", {fetch_cnt, squash_cnt}, 0);
`endif
    tick();
    reset = 1'b1;
    // 1: streaming from reset
    for (int k = 0; k < 6; k++) begin
      sample();
      check("t1_addr", imem_addr, k);
      check("t1_valid", inst_valid, k > 0);
      if (k > 0) check("t1_pc", inst_pc, k - 1);
      tick();
    end
    // 2: back-pressure
    inst_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("bp_valid", inst_valid, 1);
      check("bp_pc", inst_pc, 5);
      check("bp_addr", imem_addr, 6);
      tick();
    end
    inst_ready = 1'b1;
    sample(); check("drain_valid", inst_valid, 1); check("drain_pc", inst_pc, 5); tick();
    sample(); check("drain_bubble", inst_valid, 0); tick();
    sample(); check("resume_pc", inst_pc, 6); tick();
    // 3: redirect with the buffer full
    inst_ready = 1'b0;
    sample(); check("t3_infl", inst_pc, 7); tick();
    sample(); check("t3_buf", inst_pc, 7); tick();
    redirect_valid = 1'b1; redirect_pc = 6'd40;
    sample(); check("sq_valid", inst_valid, 0); tick();
    redirect_valid = 1'b0; inst_ready = 1'b1;
    sample(); check("tgt_valid", inst_valid, 1); check("tgt_pc", inst_pc, 40);
`ifdef IFETCH_PERF_EN
    check("squash_cnt", squash_cnt, 1);
`endif
    tick();
    sample(); check("tgt_next", inst_pc, 41); tick();
    // 4: wrap at end of memory
    redirect_valid = 1'b1; redirect_pc = 6'd62;
    sample(); tick();
    redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      check("wrap_valid", inst_valid, 1);
      check("wrap_pc", inst_pc, (62 + k) % 64);
      tick();
    end
    // 5: stall
    stall = 1'b1;
    sample(); check("st_deliver", inst_valid, 1); check("st_pc", inst_pc, 2); check("st_addr", imem_addr, 3); tick();
    sample(); check("st_bubble1", inst_valid, 0); tick();
    stall = 1'b0;
    sample(); check("st_bubble2", inst_valid, 0); check("st_addr2", imem_addr, 3); tick();
    sample(); check("st_resume", inst_pc, 3); tick();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 6'd20;
    sample(); tick();
    redirect_valid = 1'b0;
    sample(); check("st_redir_addr", imem_addr, 20); check("st_redir_valid", inst_valid, 0); tick();
    stall = 1'b0;
    sample(); check("st_redir_issue", inst_valid, 0); tick();
    // 6: reset while the buffer holds a word
    inst_ready = 1'b0;
    sample(); check("t6_pc", inst_pc, 20); tick();
    sample(); check("t6_buf", inst_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("arst_valid", inst_valid, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_out", inst_out, 0);
`ifdef IFETCH_PERF_EN
    check("arst_cnts", {fetch_cnt, squash_cnt}, 0);
`endif
    model_reset();
    inst_ready = 1'b1;
    tick();
    sample(); tick();
    reset = 1'b1;
    sample(); check("rel_valid", inst_valid, 0); check("rel_addr", imem_addr, 0); tick();
    sample(); check("rel_pc", inst_pc, 0); check("rel_valid2", inst_valid, 1); tick();
    // random traffic against the stream model
    hs = 0;
    for (int c = 0; c < 600; c++) begin
      inst_ready = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 5) == 0;
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_pc = addr_t'($urandom_range(0, 63));
      sample();
      tick();
    end
    check("progress", hs > 60, 1);
    stall = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b1;
    begin
      int w = 0;
      do begin sample(); tick(); w++; end while (!inst_valid && w < 6);
      check("live", inst_valid, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
